// File: rtl/mem_port_arbiter_pkg.sv
// Shared bus types for the fetch/data/memory ports and the helpers that build
// a memory-port request from a fetch or data request.
package mem_port_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } mbus_req_t;

    typedef struct packed {
        logic        ready;
        logic [63:0] data;
    } mbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [2:0] FETCH_SIZE = 3'b010;

    // Fetches are always 32-bit reads with no byte enables.
    function automatic mbus_req_t latch_fetch(input ibus_req_t r);
        mbus_req_t m;
        m          = '0;
        m.valid    = r.valid;
        m.addr     = r.addr;
        m.size     = FETCH_SIZE;
        return m;
    endfunction

    function automatic mbus_req_t latch_data(input dbus_req_t r);
        mbus_req_t m;
        m.valid    = r.valid;
        m.is_write = |r.strobe;
        m.addr     = r.addr;
        m.size     = r.size;
        m.strobe   = r.strobe;
        m.data     = r.data;
        return m;
    endfunction

    function automatic logic [31:0] fetch_word(input logic [63:0] data, input logic hi);
        return hi ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared memory port buses; the arbiter uses the
// slave view, whatever drives requests and memory responses uses the master view.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
();
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    mbus_req_t  mreq;
    mbus_resp_t mresp;

    modport slave (
        input  ireq,
        input  dreq,
        input  mresp,
        output iresp,
        output dresp,
        output mreq
    );

    modport master (
        output ireq,
        output dreq,
        output mresp,
        input  iresp,
        input  dresp,
        input  mreq
    );
endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin pick between the fetch and data requesters.
module arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last_grant,
    output logic   grant_valid,
    output owner_t grant_owner
);
    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant_valid = req_i | req_d;
        grant_owner = OWN_I;
        if (req_i && req_d) begin
            grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (req_d) begin
            grant_owner = OWN_D;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port, with a
// per-transaction watchdog and a data-side wait counter.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              timeout_err,
    output logic [31:0]       dwait_cnt
);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    arb_state_t state;
    owner_t     last_grant;
    owner_t     pick_owner;
    logic       pick_valid;
    mbus_req_t  req_q;
    logic [31:0] wd_cnt;
    ibus_resp_t iresp_c;
    dbus_resp_t dresp_c;

    arb_rr2 u_rr2 (
        .req_i       (bus.ireq.valid),
        .req_d       (bus.dreq.valid),
        .last_grant  (last_grant),
        .grant_valid (pick_valid),
        .grant_owner (pick_owner)
    );

    // The memory request is only ever the latched copy, so requesters may change
    // or drop their request mid-transaction without disturbing the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= OWN_D;
            req_q       <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        wd_cnt <= '0;
                        if (pick_owner == OWN_D) begin
                            state <= BUSY_D;
                            req_q <= latch_data(bus.dreq);
                        end else begin
                            state <= BUSY_I;
                            req_q <= latch_fetch(bus.ireq);
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mresp.ready || wd_cnt == WD_LAST) begin
                        state      <= IDLE;
                        req_q      <= '0;
                        last_grant <= (state == BUSY_D) ? OWN_D : OWN_I;
                        if (!bus.mresp.ready) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dwait_cnt <= '0;
        end else if (bus.dreq.valid && state != BUSY_D && dwait_cnt != 32'hFFFF_FFFF) begin
            dwait_cnt <= dwait_cnt + 32'd1;
        end
    end

    // Completion is acknowledged combinationally in the ready cycle, owner only.
    always_comb begin
        iresp_c = '0;
        dresp_c = '0;
        if (state == BUSY_I && bus.mresp.ready) begin
            iresp_c.addr_ok = 1'b1;
            iresp_c.data_ok = 1'b1;
            iresp_c.data    = fetch_word(bus.mresp.data, req_q.addr[2]);
        end
        if (state == BUSY_D && bus.mresp.ready) begin
            dresp_c.addr_ok = 1'b1;
            dresp_c.data_ok = 1'b1;
            dresp_c.data    = bus.mresp.data;
        end
    end

    assign bus.mreq  = req_q;
    assign bus.iresp = iresp_c;
    assign bus.dresp = dresp_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        logic        is_d;
        logic [63:0] data;
    } exp_resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        timeout_err;
    logic [31:0] dwait_cnt;
    logic        wd_timeout_err;
    logic [31:0] wd_dwait_cnt;

    int tests = 0;
    int fails = 0;

    mbus_req_t exp_grant[$];
    exp_resp_t exp_resp[$];
    mbus_req_t mon_g;
    exp_resp_t mon_r;
    logic      prev_valid = 1'b0;

    logic [63:0] cont_rdata [4] = '{64'hAAAA_0001_BBBB_0002, 64'hCCCC_0003_DDDD_0004,
                                    64'h0102_0304_0506_0708, 64'hF0E0_D0C0_B0A0_9080};
    logic [63:0] cont_exp   [4] = '{64'h0000_0000_BBBB_0002, 64'hCCCC_0003_DDDD_0004,
                                    64'h0000_0000_0506_0708, 64'hF0E0_D0C0_B0A0_9080};

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if wbus ();

    mem_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .timeout_err (timeout_err),
        .dwait_cnt   (dwait_cnt)
    );

    mem_port_arbiter #(.TIMEOUT(4)) dut_wd (
        .clk         (clk),
        .reset       (reset),
        .bus         (wbus),
        .timeout_err (wd_timeout_err),
        .dwait_cnt   (wd_dwait_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name, input string what);
        tests++;
        fails++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    task automatic clear_inputs();
        bus.ireq   = '0;
        bus.dreq   = '0;
        bus.mresp  = '0;
        wbus.ireq  = '0;
        wbus.dreq  = '0;
        wbus.mresp = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        exp_grant.delete();
        exp_resp.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic expect_fetch(input logic [63:0] addr, input logic [63:0] word);
        mbus_req_t g;
        exp_resp_t r;
        g       = '0;
        g.valid = 1'b1;
        g.addr  = addr;
        g.size  = 3'b010;
        r.is_d  = 1'b0;
        r.data  = word;
        exp_grant.push_back(g);
        exp_resp.push_back(r);
    endtask

    task automatic expect_data(input logic [63:0] addr, input logic [2:0] size, input logic [7:0] strobe,
                               input logic [63:0] wdata, input logic is_wr, input logic [63:0] rdata);
        mbus_req_t g;
        exp_resp_t r;
        g.valid    = 1'b1;
        g.is_write = is_wr;
        g.addr     = addr;
        g.size     = size;
        g.strobe   = strobe;
        g.data     = wdata;
        r.is_d     = 1'b1;
        r.data     = rdata;
        exp_grant.push_back(g);
        exp_resp.push_back(r);
    endtask

    task automatic respond(input int waits, input logic [63:0] rdata);
        repeat (waits) tick();
        bus.mresp.ready = 1'b1;
        bus.mresp.data  = rdata;
        tick();
        bus.mresp = '0;
        #1;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!bus.mreq.valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.mreq.valid) report_fail("grant_wait", "no grant within 20 cycles");
    endtask

    // Monitor: compares every new grant and every completion against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (bus.mreq.valid && !prev_valid) begin
                if (exp_grant.size() == 0) begin
                    report_fail("grant_unexpected", "grant with no expected entry");
                end else begin
                    mon_g = exp_grant.pop_front();
                    check_output("grant_write",  bus.mreq.is_write, mon_g.is_write);
                    check_output("grant_addr",   bus.mreq.addr,     mon_g.addr);
                    check_output("grant_size",   bus.mreq.size,     mon_g.size);
                    check_output("grant_strobe", bus.mreq.strobe,   mon_g.strobe);
                    check_output("grant_data",   bus.mreq.data,     mon_g.data);
                end
            end
            if (bus.iresp.data_ok || bus.dresp.data_ok) begin
                if (exp_resp.size() == 0) begin
                    report_fail("resp_unexpected", "data_ok with no expected entry");
                end else begin
                    mon_r = exp_resp.pop_front();
                    check_output("resp_owner", bus.dresp.data_ok, mon_r.is_d);
                    if (mon_r.is_d) begin
                        check_output("resp_d_data",    bus.dresp.data,    mon_r.data);
                        check_output("resp_d_addr_ok", bus.dresp.addr_ok, 1);
                        check_output("resp_i_zero",    |bus.iresp,        0);
                    end else begin
                        check_output("resp_i_data",    bus.iresp.data,    mon_r.data);
                        check_output("resp_i_addr_ok", bus.iresp.addr_ok, 1);
                        check_output("resp_d_zero",    |bus.dresp,        0);
                    end
                end
            end
            if (wbus.iresp.data_ok || wbus.dresp.data_ok) begin
                report_fail("wd_resp_unexpected", "data_ok on a port that never sees ready");
            end
        end
        prev_valid = bus.mreq.valid;
    end

    initial begin
        #100000;
        $display("[TB] FAIL sim_limit: simulation time limit reached");
        $fatal(1, "[TB] stopped by time limit");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;

        check_output("rst_mreq",        |bus.mreq,   0);
        check_output("rst_iresp",       |bus.iresp,  0);
        check_output("rst_dresp",       |bus.dresp,  0);
        check_output("rst_timeout_err", timeout_err, 0);
        check_output("rst_dwait",       dwait_cnt,   0);

        // Single fetch from the upper word, ready in the third busy cycle.
        expect_fetch(64'h8000_0004, 64'h1111_2222);
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = 64'h8000_0004;
        tick();
        bus.ireq = '0;
        #1;
        check_output("fetch_grant_latency", bus.mreq.valid, 1);
        respond(2, 64'h1111_2222_3333_4444);
        check_output("fetch_dataok_pulse", bus.iresp.data_ok, 0);
        check_output("fetch_mreq_drop",    bus.mreq.valid,    0);

        // Sustained contention alternates I, D, I, D starting with I.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) expect_fetch(64'h8000_0100, cont_exp[k]);
            else            expect_data(64'h8000_2008, 3'd3, 8'h00, 64'h0, 1'b0, cont_exp[k]);
        end
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = 64'h8000_0100;
        bus.dreq.valid = 1'b1;
        bus.dreq.addr  = 64'h8000_2008;
        bus.dreq.size  = 3'd3;
        for (int k = 0; k < 4; k++) begin
            wait_grant();
            respond(k % 2, cont_rdata[k]);
            if (k == 0) check_output("dead_cycle", bus.mreq.valid, 0);
        end
        clear_inputs();

        // Store held stable while the requester changes and drops its request.
        expect_data(64'h8000_1000, 3'd3, 8'hFF, 64'hDEAD_BEEF, 1'b1, 64'h0);
        tick();
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = 64'h8000_1000;
        bus.dreq.size   = 3'd3;
        bus.dreq.strobe = 8'hFF;
        bus.dreq.data   = 64'hDEAD_BEEF;
        tick();
        bus.dreq = '{valid: 1'b0, addr: 64'h0, size: 3'd0, strobe: 8'h00, data: 64'h1234};
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output("store_hold_write", bus.mreq.is_write, 1);
            check_output("store_hold_addr",  bus.mreq.addr,     64'h8000_1000);
            check_output("store_hold_data",  bus.mreq.data,     64'hDEAD_BEEF);
            tick();
        end
        respond(0, 64'h0);

        // Data side waits through a 10-cycle fetch plus the dead cycle.
        do_reset();
        expect_fetch(64'h8000_0040, 64'h7777_8888);
        expect_data(64'h8000_3000, 3'd3, 8'h00, 64'h0, 1'b0, 64'h0BAD_F00D_0BAD_F00D);
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = 64'h8000_0040;
        tick();
        bus.ireq       = '0;
        bus.dreq.valid = 1'b1;
        bus.dreq.addr  = 64'h8000_3000;
        bus.dreq.size  = 3'd3;
        respond(9, 64'h5555_6666_7777_8888);
        tick();
        check_output("dwait_at_grant", dwait_cnt,      11);
        check_output("dwait_d_owner",  bus.mreq.valid, 1);
        bus.dreq = '0;
        respond(0, 64'h0BAD_F00D_0BAD_F00D);
        check_output("dwait_after", dwait_cnt, 11);

        // Reset during a data transaction, then a late ready.
        expect_data(64'h8000_4000, 3'd3, 8'h00, 64'h0, 1'b0, 64'h0);
        exp_resp.delete();
        bus.dreq.valid = 1'b1;
        bus.dreq.addr  = 64'h8000_4000;
        bus.dreq.size  = 3'd3;
        tick();
        @(negedge clk);
        #1;
        reset    = 1'b1;
        bus.dreq = '0;
        tick();
        reset           = 1'b0;
        bus.mresp.ready = 1'b1;
        bus.mresp.data  = 64'h9999_9999_9999_9999;
        #1;
        check_output("rst_busy_dataok", bus.dresp.data_ok, 0);
        check_output("rst_busy_mreq",   bus.mreq.valid,    0);
        check_output("rst_busy_dwait",  dwait_cnt,         0);
        tick();
        bus.mresp = '0;

        // Watchdog on the TIMEOUT=4 instance: ready never comes.
        wbus.ireq.valid = 1'b1;
        wbus.ireq.addr  = 64'h8000_0000;
        tick();
        wbus.ireq = '0;
        #1;
        check_output("wd_grant", wbus.mreq.valid, 1);
        repeat (3) tick();
        check_output("wd_busy_c4", wbus.mreq.valid, 1);
        check_output("wd_err_c4",  wd_timeout_err,  0);
        tick();
        check_output("wd_mreq_drop", wbus.mreq.valid, 0);
        check_output("wd_err_set",   wd_timeout_err,  1);
        wbus.mresp.ready = 1'b1;
        wbus.mresp.data  = 64'h1;
        #1;
        check_output("wd_late_ready", wbus.iresp.data_ok, 0);
        tick();
        wbus.mresp = '0;
        repeat (5) tick();
        check_output("wd_err_sticky", wd_timeout_err, 1);
        do_reset();
        check_output("wd_err_cleared", wd_timeout_err, 0);

        check_output("sb_grant_drain", exp_grant.size(), 0);
        check_output("sb_resp_drain",  exp_resp.size(),  0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
